// File: rtl/id_pc_redirect_pkg.sv
// id_pc_redirect_pkg: compare codes, branch op encodings and FSM states shared by the PC redirect block
package id_pc_redirect_pkg;
  localparam logic [1:0] EQ = 2'b00, LT = 2'b01, GT = 2'b10;
  typedef enum logic [2:0] {BR_NONE, BEQ, BNE, BLT, BGE, JAL, JALR} br_op_e;
  typedef enum logic [1:0] {BOOT, RUN, REDIR} state_e;
  function automatic logic is_cond(input logic [2:0] op);
    return op == BEQ || op == BNE || op == BLT || op == BGE;
  endfunction
endpackage

// File: rtl/id_pc_redirect_if.sv
// id_pc_redirect_if: ID-stage decision inputs and fetch-side outputs; BR_STATS_EN adds branch counters
interface id_pc_redirect_if;
  logic        stall;
  logic        id_valid;
  logic [2:0]  id_br_op;
  logic [1:0]  branch;
  logic [31:0] id_pc;
  logic [31:0] id_imm;
  logic [31:0] id_rs1;
  logic [31:0] pc;
  logic        pc_valid;
  logic        flush_if_id;
  logic        redirect;
`ifdef BR_STATS_EN
  logic [31:0] br_taken_cnt;
  logic [31:0] br_ntaken_cnt;
  modport master (output stall, id_valid, id_br_op, branch, id_pc, id_imm, id_rs1,
                  input pc, pc_valid, flush_if_id, redirect, br_taken_cnt, br_ntaken_cnt);
  modport slave  (input stall, id_valid, id_br_op, branch, id_pc, id_imm, id_rs1,
                  output pc, pc_valid, flush_if_id, redirect, br_taken_cnt, br_ntaken_cnt);
`else
  modport master (output stall, id_valid, id_br_op, branch, id_pc, id_imm, id_rs1,
                  input pc, pc_valid, flush_if_id, redirect);
  modport slave  (input stall, id_valid, id_br_op, branch, id_pc, id_imm, id_rs1,
                  output pc, pc_valid, flush_if_id, redirect);
`endif
endinterface

// File: rtl/id_pc_redirect_br_taken.sv
// id_br_taken: combinational taken decode and word-aligned redirect target
module id_br_taken import id_pc_redirect_pkg::*; (
  input  logic [2:0]  op_i,
  input  logic [1:0]  code_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] rs1_i,
  output logic        taken_o,
  output logic [31:0] target_o
);
  logic [31:0] sum;
  always_comb begin
    taken_o = op_i == BEQ ? code_i == EQ :
              op_i == BNE ? code_i != EQ :
              op_i == BLT ? code_i == LT :
              op_i == BGE ? code_i != LT :
              op_i == JAL || op_i == JALR;
    sum = (op_i == JALR ? rs1_i : pc_i) + imm_i;
    // clearing both low bits also covers the JALR bit-0 clear
    target_o = sum & ~32'h3;
  end
endmodule

// File: rtl/id_pc_redirect.sv
// id_pc_redirect: owns the fetch PC, decides taken branches in ID and flushes IF/ID; BR_STATS_EN adds counters
module id_pc_redirect import id_pc_redirect_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input logic            clk,
  input logic            rst,
  id_pc_redirect_if.slave bus
);
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, target;
  logic        pc_valid_q, redirect_q, redirect_d, taken, qual, live;
  id_br_taken u_taken (
    .op_i     (bus.id_br_op),
    .code_i   (bus.branch),
    .pc_i     (bus.id_pc),
    .imm_i    (bus.id_imm),
    .rs1_i    (bus.id_rs1),
    .taken_o  (taken),
    .target_o (target)
  );
  always_comb begin
    live       = bus.id_valid & (state_q == RUN) & ~bus.stall;
    qual       = taken & live;
    state_d    = state_q == RUN ? (qual ? REDIR : RUN) : RUN;
    pc_d       = state_q == BOOT ? RESET_PC : bus.stall ? pc_q : qual ? target : pc_q + PC_STEP;
    redirect_d = qual;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      pc_valid_q <= 1'b0;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= 1'b1;
      redirect_q <= redirect_d;
    end
  end
  assign bus.pc          = pc_q;
  assign bus.pc_valid    = pc_valid_q;
  assign bus.redirect    = redirect_q;
  assign bus.flush_if_id = qual;
`ifdef BR_STATS_EN
  logic [31:0] tcnt_q, tcnt_d, ncnt_q, ncnt_d;
  logic        cond;
  always_comb begin
    cond   = live & is_cond(bus.id_br_op);
    tcnt_d = cond && taken && tcnt_q != '1 ? tcnt_q + 32'd1 : tcnt_q;
    ncnt_d = cond && !taken && ncnt_q != '1 ? ncnt_q + 32'd1 : ncnt_q;
  end
  always_ff @(posedge clk) begin
    tcnt_q <= rst ? '0 : tcnt_d;
    ncnt_q <= rst ? '0 : ncnt_d;
  end
  assign bus.br_taken_cnt  = tcnt_q;
  assign bus.br_ntaken_cnt = ncnt_q;
`endif
endmodule

// File: tb/tb_id_pc_redirect.sv
// tb_id_pc_redirect: directed stimulus with a queue of expected post-edge fetch state
module tb_id_pc_redirect;
  import id_pc_redirect_pkg::*;
  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        pv;
    logic        rd;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];
  id_pc_redirect_if bus();
  id_pc_redirect dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic id(input logic v, input logic [2:0] op, input logic [1:0] c,
                    input logic [31:0] p, input logic [31:0] imm, input logic [31:0] rs1);
    bus.id_valid = v;
    bus.id_br_op = op;
    bus.branch   = c;
    bus.id_pc    = p;
    bus.id_imm   = imm;
    bus.id_rs1   = rs1;
  endtask
  task automatic cyc(input string tag, input logic ef, input logic [31:0] epc,
                     input logic epv, input logic erd);
    exp_t e;
    #1 chk({tag, ".flush"}, 32'(bus.flush_if_id), 32'(ef));
    sb.push_back('{tag, epc, epv, erd});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".pc"}, bus.pc, e.pc);
    chk({e.tag, ".pc_valid"}, 32'(bus.pc_valid), 32'(e.pv));
    chk({e.tag, ".redirect"}, 32'(bus.redirect), 32'(e.rd));
  endtask
  initial begin
    bus.stall = 1'b0;
    id(1'b0, BR_NONE, EQ, 32'h0, 32'h0, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset.pc", bus.pc, 32'h0);
    chk("reset.pc_valid", 32'(bus.pc_valid), 32'h0);
    chk("reset.redirect", 32'(bus.redirect), 32'h0);
    rst = 1'b0;
    cyc("boot", 1'b0, 32'h0, 1'b1, 1'b0);
    cyc("seq4", 1'b0, 32'h4, 1'b1, 1'b0);
    cyc("seq8", 1'b0, 32'h8, 1'b1, 1'b0);
    cyc("seq12", 1'b0, 32'hC, 1'b1, 1'b0);
    id(1'b1, BEQ, EQ, 32'h10, 32'h20, 32'h0);
    cyc("beq_taken", 1'b1, 32'h30, 1'b1, 1'b1);
    cyc("redir_ignores_id", 1'b0, 32'h34, 1'b1, 1'b0);
    id(1'b1, BNE, EQ, 32'h40, 32'h8, 32'h0);
    cyc("bne_eq_nt", 1'b0, 32'h38, 1'b1, 1'b0);
    id(1'b1, BGE, GT, 32'h40, 32'h100, 32'h0);
    cyc("bge_gt_t", 1'b1, 32'h140, 1'b1, 1'b1);
    id(1'b0, BR_NONE, EQ, 32'h0, 32'h0, 32'h0);
    cyc("after_bge", 1'b0, 32'h144, 1'b1, 1'b0);
    id(1'b1, BLT, GT, 32'h50, 32'h8, 32'h0);
    cyc("blt_gt_nt", 1'b0, 32'h148, 1'b1, 1'b0);
    id(1'b1, BGE, 2'b11, 32'h60, 32'h10, 32'h0);
    cyc("bge_code3_t", 1'b1, 32'h70, 1'b1, 1'b1);
    id(1'b0, BR_NONE, EQ, 32'h0, 32'h0, 32'h0);
    cyc("after_code3", 1'b0, 32'h74, 1'b1, 1'b0);
    id(1'b1, BLT, 2'b11, 32'h60, 32'h10, 32'h0);
    cyc("blt_code3_nt", 1'b0, 32'h78, 1'b1, 1'b0);
    id(1'b1, BLT, LT, 32'h200, 32'hFFFF_FF00, 32'h0);
    bus.stall = 1'b1;
    cyc("stall1", 1'b0, 32'h78, 1'b1, 1'b0);
    cyc("stall2", 1'b0, 32'h78, 1'b1, 1'b0);
    bus.stall = 1'b0;
    cyc("blt_unstall", 1'b1, 32'h100, 1'b1, 1'b1);
    id(1'b0, BR_NONE, EQ, 32'h0, 32'h0, 32'h0);
    cyc("after_blt", 1'b0, 32'h104, 1'b1, 1'b0);
    id(1'b1, JALR, EQ, 32'h0, 32'h4, 32'h1001);
    cyc("jalr", 1'b1, 32'h1004, 1'b1, 1'b1);
    id(1'b0, BR_NONE, EQ, 32'h0, 32'h0, 32'h0);
    cyc("after_jalr", 1'b0, 32'h1008, 1'b1, 1'b0);
    id(1'b1, JAL, EQ, 32'hFFFF_FFFC, 32'h8, 32'h0);
    cyc("jal_wrap", 1'b1, 32'h4, 1'b1, 1'b1);
    id(1'b0, BR_NONE, EQ, 32'h0, 32'h0, 32'h0);
    cyc("after_jal", 1'b0, 32'h8, 1'b1, 1'b0);
    id(1'b1, BEQ, EQ, 32'h10, 32'h3, 32'h0);
    cyc("beq_align", 1'b1, 32'h10, 1'b1, 1'b1);
`ifdef BR_STATS_EN
    chk("taken_cnt", bus.br_taken_cnt, 32'd5);
    chk("ntaken_cnt", bus.br_ntaken_cnt, 32'd3);
`endif
    rst = 1'b1;
    cyc("rst_in_redir", 1'b0, 32'h0, 1'b0, 1'b0);
`ifdef BR_STATS_EN
    chk("taken_cnt_clr", bus.br_taken_cnt, 32'd0);
    chk("ntaken_cnt_clr", bus.br_ntaken_cnt, 32'd0);
`endif
    rst = 1'b0;
    id(1'b1, BR_NONE, EQ, 32'h20, 32'h40, 32'h0);
    cyc("reboot", 1'b0, 32'h0, 1'b1, 1'b0);
    cyc("none_valid", 1'b0, 32'h4, 1'b1, 1'b0);
    id(1'b0, JAL, EQ, 32'h20, 32'h40, 32'h0);
    cyc("jal_bubble", 1'b0, 32'h8, 1'b1, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
